// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial word datapath (serializer
//               and receiver): default word width and shift-direction codes.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Default word width used by both ends of the serial link.
    localparam int DEFAULT_WORD_WIDTH = 8;

    // Shift direction codes.
    // MSB-first: bits enter at the LSB and the register shifts left.
    // LSB-first: bits enter at the MSB and the register shifts right.
    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/rx_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : rx_shift_stage
// Description : Combinational next-value logic for the receive shift register.
//               Shifts one serial bit into the register in either direction,
//               mirroring the left/right shift datapath on the transmit side.
// Ports       : shift_in  [WIDTH] current shift-register contents
//               bit_in    [1]     serial bit to insert
//               dir       [1]     DIR_MSB_FIRST (shift left) / DIR_LSB_FIRST
//               shift_out [WIDTH] shift-register contents after insertion
// Revision    : 1.0 - initial release
// ============================================================================
module rx_shift_stage
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic [WIDTH-1:0] shift_in,
    input  logic             bit_in,
    input  logic             dir,
    output logic [WIDTH-1:0] shift_out
);

    always_comb begin
        shift_out = shift_in;
        if (dir == DIR_MSB_FIRST) begin
            // New bit enters at the LSB; earliest bit ends up at the MSB.
            shift_out = {shift_in[WIDTH-2:0], bit_in};
        end else begin
            // New bit enters at the MSB; earliest bit ends up at the LSB.
            shift_out = {bit_in, shift_in[WIDTH-1:1]};
        end
    end

endmodule : rx_shift_stage
`default_nettype wire

// File: rtl/serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_rx
// Description : Serial-to-parallel receiver. Collects one bit per bit_valid
//               strobe into a WIDTH-bit word (MSB-first or LSB-first, chosen
//               at the first bit of each word) and presents completed words
//               through a one-entry valid/ready buffer. A word that completes
//               while the buffer is still occupied is dropped and flagged on
//               the sticky overrun output.
// Ports       : clk        [1]     system clock, rising edge
//               rst_n      [1]     asynchronous active-low reset
//               bit_in     [1]     serial data bit
//               bit_valid  [1]     bit_in valid this cycle
//               msb_first  [1]     word order, sampled at the first bit
//               clear      [1]     abort partial word, clear overrun
//               word_out   [WIDTH] assembled word
//               word_valid [1]     output buffer holds an unread word
//               word_ready [1]     consumer accepts word_out
//               bit_count  [CW]    bits in the current partial word
//               overrun    [1]     sticky: a completed word was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_rx
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_dir;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_dir;
    logic             w_accept;
    logic             w_last;
    logic             w_xfer;
    logic             w_load;

    // The first bit of a word uses msb_first directly; later bits use the
    // direction latched on that first bit.
    assign w_dir    = (r_count == '0) ? msb_first : r_dir;
    // clear has priority: a bit strobed together with clear is discarded.
    assign w_accept = bit_valid & ~clear;
    assign w_last   = w_accept & (r_count == c_last_bit);
    assign w_xfer   = r_valid & word_ready;
    // A completed word may load when the buffer is empty or is being read
    // in the same cycle, which gives bubble-free back-to-back words.
    assign w_load   = w_last & (~r_valid | word_ready);

    rx_shift_stage #(
        .WIDTH (WIDTH)
    ) u_shift_stage (
        .shift_in  (r_shift),
        .bit_in    (bit_in),
        .dir       (w_dir),
        .shift_out (w_shift_next)
    );

    // Partial-word collection: shift register, bit counter, direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else if (clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (bit_valid) begin
            r_shift <= w_shift_next;
            if (r_count == '0) begin
                r_dir <= msb_first;
            end
            r_count <= w_last ? '0 : r_count + CW'(1);
        end
    end

    // One-entry output buffer and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_word  <= w_shift_next;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (clear) begin
                r_overrun <= 1'b0;
            end else if (w_last && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign bit_count  = r_count;
    assign overrun    = r_overrun;

endmodule : serial_word_rx
`default_nettype wire

// File: tb/tb_serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_rx
// Description : Self-checking bench for serial_word_rx (WIDTH=8). Directed
//               scenarios followed by a randomized run, all compared against
//               a word-level reference model kept as a queue of received bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_rx;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_in;
    logic          bit_valid;
    logic          msb_first;
    logic          clear;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          word_ready;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit           m_bits[$];
    bit           m_dir;
    logic [W-1:0] m_word;
    bit           m_valid;
    bit           m_ovr;

    always #5 clk = ~clk;

    serial_word_rx #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .msb_first  (msb_first),
        .clear      (clear),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Word built from the bit queue: the first received bit is the MSB for
    // MSB-first order and the LSB for LSB-first order.
    function automatic logic [W-1:0] assemble(input bit dir, input bit bits[$]);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (dir) w[W-1-i] = bits[i];
            else     w[i]     = bits[i];
        end
        return w;
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b1;
        m_word  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".word_out"},   32'(word_out),   32'(m_word));
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
        chk({tag, ".bit_count"},  32'(bit_count),  32'(m_bits.size()));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after.
    task automatic step(input bit bv, input bit b, input bit mf, input bit clr,
                        input bit rdy, input string tag);
        bit           xfer;
        bit           load;
        logic [W-1:0] wnew;
        bit_valid  = bv;
        bit_in     = b;
        msb_first  = mf;
        clear      = clr;
        word_ready = rdy;
        @(posedge clk);
        xfer = m_valid && rdy;
        load = 1'b0;
        wnew = '0;
        if (clr) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (bv) begin
            if (m_bits.size() == 0) m_dir = mf;
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                wnew = assemble(m_dir, m_bits);
                m_bits.delete();
                if (!m_valid || rdy) load = 1'b1;
                else                 m_ovr = 1'b1;
            end
        end
        if (load) begin
            m_word  = wnew;
            m_valid = 1'b1;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    // Sends seq[W-1] first.
    task automatic send_stream(input logic [W-1:0] seq, input bit mf, input bit rdy,
                               input string tag);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, seq[i], mf, 1'b0, rdy, tag);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, rdy, "idle");
    endtask

    initial begin
        int pulses;
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        msb_first  = 1'b1;
        clear      = 1'b0;
        word_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // MSB-first 0x1B: word_valid high exactly one cycle after bit 8.
        idle(1, 1'b1);
        send_stream(8'h1B, 1'b1, 1'b1, "msb");
        chk("msb_word", 32'(word_out), 32'h1B);
        chk("msb_valid", 32'(word_valid), 32'd1);
        idle(1, 1'b1);
        chk("msb_valid_drop", 32'(word_valid), 32'd0);

        // LSB-first, same bit sequence.
        send_stream(8'h1B, 1'b0, 1'b1, "lsb");
        chk("lsb_word", 32'(word_out), 32'hD8);
        idle(1, 1'b1);

        // Direction toggled mid-word is ignored; next word follows new order.
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, 1'(8'h1B >> i), (i > W - 4), 1'b0, 1'b1, "toggle");
        end
        chk("toggle_word", 32'(word_out), 32'h1B);
        send_stream(8'hA5, 1'b0, 1'b1, "toggle2");
        chk("toggle2_word", 32'(word_out), 32'(rev(8'hA5)));
        idle(1, 1'b1);

        // Backpressure: second word dropped, overrun sticky until clear.
        send_stream(8'h1B, 1'b1, 1'b0, "bp1");
        send_stream(8'hA5, 1'b1, 1'b0, "bp2");
        chk("bp_word", 32'(word_out), 32'h1B);
        chk("bp_overrun", 32'(overrun), 32'd1);
        idle(1, 1'b1);
        chk("bp_valid_drop", 32'(word_valid), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "bp_clear");
        chk("bp_overrun_clr", 32'(overrun), 32'd0);

        // Back-to-back words with continuous bits.
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            logic [W-1:0] seq;
            seq = (k == 0) ? 8'h1B : (k == 1) ? 8'hA5 : 8'h3C;
            for (int i = W - 1; i >= 0; i--) begin
                step(1'b1, seq[i], 1'b1, 1'b0, 1'b1, "b2b");
                if (word_valid) pulses++;
            end
            chk("b2b_word", 32'(word_out), 32'(seq));
        end
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        idle(1, 1'b1);

        // Abort: clear with a simultaneous bit drops it.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "abort_pre");
        chk("abort_count5", 32'(bit_count), 32'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "abort_clr");
        chk("abort_count0", 32'(bit_count), 32'd0);
        send_stream(8'hA5, 1'b1, 1'b1, "abort_word");
        chk("abort_word_val", 32'(word_out), 32'hA5);

        // Asynchronous reset mid-word with a buffered word.
        send_stream(8'h3C, 1'b1, 1'b0, "rst_fill");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rst_part");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_word_rx
`default_nettype wire
